// File: rtl/pic_pixel_streamer_if.sv
// Pixel stream interface between the picture-memory streamer and its consumer.
//   px_data  : pixel value
//   px_valid : px_data is valid
//   px_ready : consumer accepts the pixel this cycle
//   px_last  : final pixel of the current transfer
// master = streamer side, slave = consumer side.
interface pic_pixel_streamer_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] px_data;
    logic             px_valid;
    logic             px_ready;
    logic             px_last;

    modport master (output px_data, px_valid, px_last, input px_ready);
    modport slave  (input px_data, px_valid, px_last, output px_ready);
endinterface

// File: rtl/pic_pixel_streamer.sv
// Read-side front end for the picture memory. A start command walks a
// contiguous word range, issuing one read per cycle while buffer credit
// allows. Returned words are buffered in a small FIFO and unpacked into
// pixels (lowest byte first) on a valid/ready stream.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : one-cycle command, ignored unless idle
//   base_addr           : first word address (sampled with start)
//   word_count          : number of words to read (sampled with start)
//   busy, done          : transfer in progress / one-cycle end pulse
//   mem_address,mem_wren: picture memory address, write enable (always 0)
//   mem_q               : picture memory read data
//   px                  : pixel stream (master side)
module pic_pixel_streamer #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 48,
    parameter int PIX_W        = 8,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_wren,
    input  logic [DATA_W-1:0]   mem_q,
    pic_pixel_streamer_if.master px
);
    localparam int PPW   = DATA_W / PIX_W;
    localparam int K_W   = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    generate
        if (DATA_W % PIX_W != 0) begin : g_bad_ratio
            $error("DATA_W must be an integer multiple of PIX_W");
        end
        if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
            $error("READ_LATENCY must be 1..3");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;
    state_t state;

    logic [ADDR_W-1:0]       next_addr;
    logic [ADDR_W:0]         words_left;
    logic [ADDR_W:0]         unpack_left;
    logic                    addr_vld_p0;
    logic [READ_LATENCY-1:0] ret_vld_p;
    logic [CNT_W-1:0]        inflight;

    logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        fifo_cnt;

    logic [DATA_W-1:0]       word;
    logic [K_W-1:0]          k;
    logic                    vld;
    logic                    word_last;

    logic start_go, issue, credit_ok, ret, hs, at_end, slot;
    logic load_fifo, load_bypass, push, pop;
    logic [ADDR_W-1:0] issue_addr;

    assign start_go    = (state == IDLE) && start;
    assign credit_ok   = ({1'b0, fifo_cnt} + {1'b0, inflight}) < (CNT_W + 1)'(FIFO_DEPTH);
    // The first read is issued straight from the start command so the base
    // address reaches memory in the cycle right after start.
    assign issue       = (start_go && word_count != '0) ||
                         (state == FETCH && words_left != '0 && credit_ok);
    assign issue_addr  = start_go ? base_addr : next_addr;
    assign ret         = ret_vld_p[READ_LATENCY-1];
    assign hs          = vld && px.px_ready;
    assign at_end      = (k == K_W'(PPW - 1));
    assign slot        = !vld || (hs && at_end);
    assign load_fifo   = slot && (fifo_cnt != '0);
    // An empty FIFO lets a returning word go straight into the unpacker,
    // which saves a cycle of first-pixel latency.
    assign load_bypass = slot && (fifo_cnt == '0) && ret;
    assign push        = ret && !load_bypass;
    assign pop         = load_fifo;

    assign mem_wren    = 1'b0;
    assign px.px_valid = vld;
    assign px.px_data  = word[PIX_W*k +: PIX_W];
    assign px.px_last  = vld && word_last && at_end;

    // Control FSM and read address generation
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_address <= '0;
            next_addr   <= '0;
            words_left  <= '0;
        end else begin
            done <= 1'b0;
            if (issue) begin
                mem_address <= issue_addr;
                next_addr   <= issue_addr + ADDR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            busy       <= 1'b1;
                            words_left <= word_count - (ADDR_W + 1)'(1);
                        end
                    end
                end
                FETCH: begin
                    if (words_left == '0) begin
                        state <= DRAIN;
                    end else if (issue) begin
                        words_left <= words_left - (ADDR_W + 1)'(1);
                    end
                end
                DRAIN: begin
                    // The last-pixel handshake implies nothing is in flight
                    // and the FIFO is empty.
                    if (hs && px.px_last) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p0: address presented; ret_vld_p tracks it through memory latency
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_vld_p0 <= 1'b0;
            ret_vld_p   <= '0;
            inflight    <= '0;
        end else begin
            addr_vld_p0 <= issue;
            ret_vld_p   <= (ret_vld_p << 1) | READ_LATENCY'(addr_vld_p0);
            inflight    <= inflight + CNT_W'(issue) - CNT_W'(ret);
        end
    end

    // Return stage: word buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_q;
    end

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && fifo_cnt == CNT_W'(FIFO_DEPTH)));

    // Output stage: unpacker
    always_ff @(posedge clk) begin
        if (rst) begin
            vld         <= 1'b0;
            k           <= '0;
            word_last   <= 1'b0;
            unpack_left <= '0;
        end else begin
            if (slot) begin
                k <= '0;
                if (load_fifo || load_bypass) begin
                    vld         <= 1'b1;
                    word_last   <= (unpack_left == (ADDR_W + 1)'(1));
                    unpack_left <= unpack_left - (ADDR_W + 1)'(1);
                end else begin
                    vld <= 1'b0;
                end
            end else if (hs) begin
                k <= k + K_W'(1);
            end
            if (start_go && word_count != '0) unpack_left <= word_count;
        end
    end

    always_ff @(posedge clk) begin
        if (load_fifo)        word <= fifo_mem[rd_ptr];
        else if (load_bypass) word <= mem_q;
    end
endmodule

// File: tb/tb_pic_pixel_streamer.sv
module tb_pic_pixel_streamer;
    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [18:0]      base_addr;
    logic [19:0]      word_count;
    logic             px_ready;
    logic [2:0]       v_busy, v_done, v_wren, v_valid, v_last;
    logic [2:0][18:0] v_addr;
    logic [2:0][7:0]  v_data;
    int               cyc = 0;
    int               n_chk = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: word a holds bytes 6a+1 .. 6a+6 (mod 256), lowest first.
    function automatic logic [47:0] mem_word(input logic [18:0] a);
        logic [47:0] w;
        logic [31:0] b;
        b = 32'(a) * 6 + 1;
        for (int i = 0; i < 6; i++) w[8*i +: 8] = 8'(b + 32'(i));
        return w;
    endfunction

    function automatic logic [7:0] exp_px(input logic [18:0] b, input int j);
        logic [18:0] a;
        a = b + 19'(j / 6);
        return 8'(32'(a) * 6 + 1 + 32'(j % 6));
    endfunction

    // Three instances, READ_LATENCY 1..3, all driven by the same inputs.
    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            localparam int L = g + 1;
            pic_pixel_streamer_if #(.PIX_W(8)) pif ();
            logic [18:0] addr_d [L];
            logic [47:0] q;
            assign pif.px_ready = px_ready;
            assign v_valid[g]   = pif.px_valid;
            assign v_last[g]    = pif.px_last;
            assign v_data[g]    = pif.px_data;
            always @(posedge clk) begin
                addr_d[0] <= v_addr[g];
                for (int i = 1; i < L; i++) addr_d[i] <= addr_d[i-1];
            end
            assign q = mem_word(addr_d[L-1]);
            pic_pixel_streamer #(.READ_LATENCY(L)) dut (
                .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
                .word_count(word_count), .busy(v_busy[g]), .done(v_done[g]),
                .mem_address(v_addr[g]), .mem_wren(v_wren[g]), .mem_q(q), .px(pif)
            );
        end
    endgenerate

    typedef struct {
        logic [18:0] base;
        int          count;
        int          mode;     // 0 ready=1, 1 ready 1,0,0,1..., 2 30-cycle stall
        bit          inject;   // pulse a second start mid-transfer
        logic [18:0] a1, a2, a3;
        logic [7:0]  fpx, lpx;
    } vec_t;

    logic [18:0] m_base;
    int          m_n;
    int          pix_n [3];
    int          first_cyc [3];
    int          last_cyc [3];
    int          done_cyc [3];
    logic [7:0]  first_px [3];
    logic [7:0]  last_px [3];
    bit          stall_prev [3];
    logic [9:0]  prev_vec [3];

    function automatic void chk(input string nm, input int inst,
                                input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, inst, act, exp);
        end
    endfunction

    function automatic bit rdy(input int mode, input int s);
        case (mode)
            1:       return (s % 4 == 0) || (s % 4 == 3);
            2:       return !(s >= 11 && s < 41);
            default: return 1'b1;
        endcase
    endfunction

    task automatic mon_setup(input logic [18:0] b, input int n);
        m_base = b;
        m_n    = n;
        for (int i = 0; i < 3; i++) begin
            pix_n[i] = 0; first_cyc[i] = -1; last_cyc[i] = -1; done_cyc[i] = -1;
            first_px[i] = '0; last_px[i] = '0; stall_prev[i] = 1'b0;
        end
    endtask

    // Samples all instances on the falling edge, then returns 1 after the
    // next rising edge so the caller can drive the following cycle.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (stall_prev[i]) chk("hold", i, {54'd0, v_valid[i], v_last[i], v_data[i]},
                                   {54'd0, prev_vec[i]});
            if (v_valid[i] && first_cyc[i] < 0) first_cyc[i] = cyc;
            if (v_valid[i] && px_ready) begin
                chk("px_data", i, v_data[i], exp_px(m_base, pix_n[i]));
                chk("px_last", i, v_last[i], pix_n[i] == m_n - 1);
                if (pix_n[i] == 0) first_px[i] = v_data[i];
                last_px[i] = v_data[i];
                if (v_last[i]) last_cyc[i] = cyc;
                pix_n[i]++;
            end
            if (v_done[i] && done_cyc[i] < 0) done_cyc[i] = cyc;
            stall_prev[i] = v_valid[i] && !px_ready;
            prev_vec[i]   = {v_valid[i], v_last[i], v_data[i]};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_xfer(input vec_t v);
        int          t0;
        bit          all_done;
        logic [18:0] held;
        mon_setup(v.base, v.count * 6);
        t0 = cyc;
        start = 1'b1; base_addr = v.base; word_count = 20'(v.count);
        px_ready = rdy(v.mode, 0);
        step();
        start = 1'b0;
        all_done = 1'b0;
        held = '0;
        for (int s = 1; s < 400 && !all_done; s++) begin
            px_ready = rdy(v.mode, s);
            if (v.inject && s == 10) begin
                start = 1'b1; base_addr = 19'd100; word_count = 20'd2;
            end else begin
                start = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                if (v.count > 0 && s == 1) begin
                    chk("addr1", i, v_addr[i], v.a1);
                    chk("busy_run", i, v_busy[i], 1);
                end
                if (v.count > 0 && s == 2) chk("addr2", i, v_addr[i], v.a2);
                if (v.count > 0 && s == 3) chk("addr3", i, v_addr[i], v.a3);
                if (v.mode == 2 && s == 40) begin
                    chk("addr_stall_hold", i, v_addr[i], held);
                    chk("addr_stall_val", i, v_addr[i], 19'd5);
                end
            end
            if (v.mode == 2 && s == 20) held = v_addr[0];
            step();
            all_done = (done_cyc[0] >= 0) && (done_cyc[1] >= 0) && (done_cyc[2] >= 0);
        end
        start = 1'b0;
        chk("xfer_timeout", 0, all_done, 1);
        for (int i = 0; i < 3; i++) begin
            chk("npix", i, pix_n[i], v.count * 6);
            if (v.count > 0) begin
                chk("first_valid_cyc", i, first_cyc[i], t0 + 3 + i);
                chk("first_px", i, first_px[i], v.fpx);
                chk("last_px", i, last_px[i], v.lpx);
                chk("done_after_last", i, done_cyc[i], last_cyc[i] + 1);
            end else begin
                chk("no_valid", i, first_cyc[i], -1);
                chk("done_zero_cnt", i, done_cyc[i], t0 + 1);
            end
            chk("busy_after", i, v_busy[i], 0);
            chk("valid_after", i, v_valid[i], 0);
        end
        px_ready = 1'b1;
        step();
    endtask

    vec_t vecs [7];
    vec_t v_rst;

    initial begin
        vecs[0] = '{19'd0,       3, 0, 1'b0, 19'd0,       19'd1,       19'd2,  8'h01, 8'h12};
        vecs[1] = '{19'd0,       3, 1, 1'b0, 19'd0,       19'd1,       19'd2,  8'h01, 8'h12};
        vecs[2] = '{19'h7FFFE,   3, 0, 1'b0, 19'h7FFFE,   19'h7FFFF,   19'h0,  8'hF5, 8'h06};
        vecs[3] = '{19'd0,       0, 0, 1'b0, 19'd0,       19'd0,       19'd0,  8'h00, 8'h00};
        vecs[4] = '{19'd16,      9, 0, 1'b1, 19'd16,      19'd17,      19'd18, 8'h61, 8'h96};
        vecs[5] = '{19'd0,       9, 2, 1'b0, 19'd0,       19'd1,       19'd2,  8'h01, 8'h36};
        vecs[6] = '{19'd0,       9, 0, 1'b0, 19'd0,       19'd1,       19'd2,  8'h01, 8'h36};
        v_rst   = '{19'd4,       1, 0, 1'b0, 19'd4,       19'd4,       19'd4,  8'h19, 8'h1E};

        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; px_ready = 1'b1;
        mon_setup(19'd0, 0);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", i, v_busy[i], 0);
            chk("rst_done", i, v_done[i], 0);
            chk("rst_valid", i, v_valid[i], 0);
            chk("rst_last", i, v_last[i], 0);
            chk("rst_addr", i, v_addr[i], 0);
            chk("wren", i, v_wren[i], 0);
        end
        rst = 1'b0;
        step();

        foreach (vecs[n]) run_xfer(vecs[n]);

        // Reset in the middle of a 9-word transfer.
        begin
            int snap [3];
            bit reached;
            mon_setup(19'd0, 54);
            start = 1'b1; base_addr = 19'd0; word_count = 20'd9; px_ready = 1'b1;
            step();
            start = 1'b0;
            reached = 1'b0;
            for (int s = 0; s < 200 && !reached; s++) begin
                if (pix_n[0] >= 20) reached = 1'b1;
                else step();
            end
            chk("reach_px20", 0, reached, 1);
            rst = 1'b1;
            step();
            rst = 1'b0;
            for (int i = 0; i < 3; i++) begin
                chk("midrst_valid", i, v_valid[i], 0);
                chk("midrst_busy", i, v_busy[i], 0);
                snap[i] = pix_n[i];
            end
            for (int s = 0; s < 10; s++) step();
            for (int i = 0; i < 3; i++) begin
                chk("midrst_no_done", i, done_cyc[i], -1);
                chk("midrst_no_pix", i, pix_n[i], snap[i]);
            end
        end
        run_xfer(v_rst);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
